ram_responder: RTL and testbench

- Word-addressed RAM model and controller that answers the CPU's memory requests: `ram_addr`, `ram_store`, `ram_ren` and `ram_wen` in; `ram_load` and `ram_state` out.
- It is the responder end of the CPU–RAM handshake that the system wrapper exposes to the testbench.
- Access latency is configurable so the CPU's stall logic can be exercised.
- Instantiated inside the system top, between the core's memory port and the `system_if` signals.

---
 rtl/ram_if.sv | 25 ++
 rtl/ram_responder.sv | 132 +++++++++++++
 tb/tb_ram_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_if.sv
// CPU-to-RAM request/response bundle: the requester drives address, data and
// read/write strobes; the responder returns load data and a 2-bit state code.
interface ram_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_store;
    logic              ram_ren;
    logic              ram_wen;
    logic [31:0]       ram_load;
    logic [1:0]        ram_state;

    // Handshake: the requester holds ren or wen (with a stable addr/store) until
    // ram_state shows ACCESS (2'b10) or ERROR (2'b11), then drops it for at least
    // one cycle; ram_load is meaningful only during ACCESS following a read.
    modport master (
        output ram_addr, ram_store, ram_ren, ram_wen,
        input  ram_load, ram_state
    );

    modport slave (
        input  ram_addr, ram_store, ram_ren, ram_wen,
        output ram_load, ram_state
    );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM with a configurable-latency responder FSM; answers one
// request at a time with FREE/BUSY/ACCESS/ERROR status.
module ram_responder #(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                LATENCY     = 2,
    parameter string             INIT_FILE   = ""
) (
    input logic  clk,
    input logic  rst,
    ram_if.slave bus
);
    localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH_WORDS);
    localparam logic [3:0]        LAST_CNT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_RESP  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] req_addr, req_addr_nxt;
    logic [31:0]       req_data, req_data_nxt;
    logic              req_ren, req_ren_nxt;
    logic              req_wen, req_wen_nxt;
    logic [31:0]       load_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              req_now;
    logic              in_ok;
    logic              changed;
    logic              accept;
    logic              do_access;
    logic [ADDR_W-1:0] in_off;
    logic [ADDR_W-1:0] word_off;
    logic [IDX_W-1:0]  idx;
    logic              unused_word_bits;

    assign req_now = bus.ram_ren | bus.ram_wen;
    assign in_off  = bus.ram_addr - BASE_ADDR;
    // Below-base addresses are rejected explicitly so the subtraction never wraps into range.
    assign in_ok   = !(bus.ram_ren && bus.ram_wen) &&
                     (bus.ram_addr[1:0] == 2'b00) &&
                     (bus.ram_addr >= BASE_ADDR) &&
                     ((in_off >> 2) < DEPTH_L);
    assign changed = (bus.ram_addr != req_addr) || (bus.ram_store != req_data) ||
                     (bus.ram_ren != req_ren) || (bus.ram_wen != req_wen);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        req_addr_nxt = req_addr;
        req_data_nxt = req_data;
        req_ren_nxt  = req_ren;
        req_wen_nxt  = req_wen;
        accept       = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_now) accept = 1'b1;
            end
            S_WAIT: begin
                if (!req_now)            state_nxt = S_IDLE;
                else if (changed)        accept    = 1'b1;
                else if (cnt == LAST_CNT) state_nxt = S_RESP;
                else                     cnt_nxt   = cnt + 4'd1;
            end
            S_RESP:  state_nxt = S_IDLE;
            S_FAULT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (accept) begin
            req_addr_nxt = bus.ram_addr;
            req_data_nxt = bus.ram_store;
            req_ren_nxt  = bus.ram_ren;
            req_wen_nxt  = bus.ram_wen;
            cnt_nxt      = 4'd0;
            if (!in_ok)            state_nxt = S_FAULT;
            else if (LATENCY == 0) state_nxt = S_RESP;
            else                   state_nxt = S_WAIT;
        end
    end

    // The access happens on the edge that enters RESP, using the request being committed.
    assign do_access        = (state_nxt == S_RESP) && !rst;
    assign word_off         = (req_addr_nxt - BASE_ADDR) >> 2;
    assign idx              = word_off[IDX_W-1:0];
    assign unused_word_bits = ^word_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            req_addr <= '0;
            req_data <= '0;
            req_ren  <= 1'b0;
            req_wen  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            req_addr <= req_addr_nxt;
            req_data <= req_data_nxt;
            req_ren  <= req_ren_nxt;
            req_wen  <= req_wen_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                         load_q <= 32'd0;
        else if (do_access && !req_wen_nxt) load_q <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (do_access && req_wen_nxt) mem[idx] <= req_data_nxt;
    end

    always_comb begin
        case (state)
            S_IDLE:  bus.ram_state = 2'b00;
            S_WAIT:  bus.ram_state = 2'b01;
            S_RESP:  bus.ram_state = 2'b10;
            S_FAULT: bus.ram_state = 2'b11;
            default: bus.ram_state = 2'b00;
        endcase
    end

    assign bus.ram_load = load_q;
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: a LATENCY=2 and a LATENCY=0 instance driven by
// directed and random requests, checked against an array model of memory.
module tb_ram_responder;
    localparam int         DEPTH  = 64;
    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam logic [1:0] ERROR  = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_if #(.ADDR_W(32)) bus_a ();
    ram_if #(.ADDR_W(32)) bus_b ();

    ram_responder #(
        .ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LATENCY(2), .INIT_FILE("")
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    ram_responder #(
        .ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LATENCY(0), .INIT_FILE("")
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // ---------------- reference model / scoreboard ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model_mem  [2][DEPTH];
    logic [31:0] model_load [2];
    int          lat        [2];
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] data);
        if (d == 0) begin
            bus_a.ram_ren = ren; bus_a.ram_wen = wen;
            bus_a.ram_addr = addr; bus_a.ram_store = data;
        end else begin
            bus_b.ram_ren = ren; bus_b.ram_wen = wen;
            bus_b.ram_addr = addr; bus_b.ram_store = data;
        end
    endtask

    task automatic sample(input int d, output logic [1:0] st, output logic [31:0] ld);
        if (d == 0) begin st = bus_a.ram_state; ld = bus_a.ram_load; end
        else        begin st = bus_b.ram_state; ld = bus_b.ram_load; end
    endtask

    // One complete request: expectations come from the memory model and the latency rule.
    task automatic op(input int d, input logic ren, input logic wen,
                      input logic [31:0] addr, input logic [31:0] data, input string tag);
        logic        ok;
        logic [1:0]  st;
        logic [1:0]  fin;
        logic [31:0] ld;
        logic [31:0] exp_ld;
        int          busy;
        int          idx;
        ok  = (ren ^ wen) && (addr % 4 == 0) && (addr < 4 * DEPTH);
        idx = ok ? int'(addr / 4) : 0;
        if (ok && ren) exp_q.push_back(model_mem[d][idx]);
        drive(d, ren, wen, addr, data);
        busy = 0;
        fin  = FREE;
        ld   = 32'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            sample(d, st, ld);
            if (st == BUSY) busy++;
            else begin
                fin = st;
                break;
            end
        end
        drive(d, 1'b0, 1'b0, addr, data);
        check({tag, ":state"}, 32'(fin), ok ? 32'(ACCESS) : 32'(ERROR));
        check({tag, ":busy"}, busy, ok ? lat[d] : 0);
        if (ok && ren) begin
            if (exp_q.size() > 0) begin
                exp_ld = exp_q.pop_front();
                check({tag, ":load"}, ld, exp_ld);
                model_load[d] = exp_ld;
            end
        end else begin
            check({tag, ":load_held"}, ld, model_load[d]);
        end
        if (ok && wen) model_mem[d][idx] = data;
        tick();
        sample(d, st, ld);
        check({tag, ":free"}, 32'(st), 32'(FREE));
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [1:0]  st;
        logic [31:0] ld;
        int          cycles;
        lat[0] = 2;
        lat[1] = 0;

        // Reset held two cycles with a pending write of 0 to 0x10 on dut_a.
        rst = 1'b1;
        drive(0, 1'b0, 1'b1, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            sample(0, st, ld);
            check("rst_a_state", 32'(st), 32'(FREE));
            check("rst_a_load", ld, 32'h0);
            sample(1, st, ld);
            check("rst_b_state", 32'(st), 32'(FREE));
            check("rst_b_load", ld, 32'h0);
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        model_load[0] = 32'h0;
        model_load[1] = 32'h0;
        tick(); sample(0, st, ld); check("post_rst_busy1", 32'(st), 32'(BUSY));
        tick(); sample(0, st, ld); check("post_rst_busy2", 32'(st), 32'(BUSY));
        tick(); sample(0, st, ld); check("post_rst_access", 32'(st), 32'(ACCESS));
        drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
        tick(); sample(0, st, ld); check("post_rst_free", 32'(st), 32'(FREE));
        model_mem[0][4] = 32'h0;

        // Give every word a known value.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++)
                op(d, 1'b0, 1'b1, 32'(w * 4), $urandom, "preload");

        // Write then read, both latencies.
        op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
        op(0, 1'b1, 1'b0, 32'h10, 32'h0, "rd_10");
        op(1, 1'b0, 1'b1, 32'h4, 32'h12345678, "l0_wr_4");
        op(1, 1'b1, 1'b0, 32'h4, 32'h0, "l0_rd_4");

        // Faults leave memory untouched.
        op(0, 1'b1, 1'b0, 32'h3, 32'h0, "flt_misalign_rd");
        op(0, 1'b1, 1'b1, 32'h10, 32'h11111111, "flt_both");
        op(0, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, "flt_range_rd");
        op(0, 1'b0, 1'b1, 32'h22, 32'h22222222, "flt_misalign_wr");
        op(0, 1'b0, 1'b1, 32'(4 * DEPTH), 32'h33333333, "flt_range_wr");
        op(1, 1'b0, 1'b1, 32'h5, 32'h44444444, "l0_flt_wr");
        op(0, 1'b1, 1'b0, 32'h10, 32'h0, "flt_rb_10");
        op(0, 1'b1, 1'b0, 32'h20, 32'h0, "flt_rb_20");
        op(1, 1'b1, 1'b0, 32'h4, 32'h0, "l0_flt_rb_4");

        // Abort: drop wen during BUSY.
        drive(0, 1'b0, 1'b1, 32'h20, 32'h0000AAAA);
        tick(); sample(0, st, ld); check("abort_busy", 32'(st), 32'(BUSY));
        drive(0, 1'b0, 1'b0, 32'h20, 32'h0000AAAA);
        tick(); sample(0, st, ld); check("abort_free", 32'(st), 32'(FREE));
        op(0, 1'b1, 1'b0, 32'h20, 32'h0, "abort_rb_20");

        // Address change mid-BUSY restarts the latency count.
        drive(0, 1'b0, 1'b1, 32'h20, 32'h0000AAAA);
        tick(); sample(0, st, ld); check("chg_busy", 32'(st), 32'(BUSY));
        drive(0, 1'b0, 1'b1, 32'h24, 32'h0000AAAA);
        cycles = 0;
        st = BUSY;
        for (int i = 0; i < 20; i++) begin
            tick();
            sample(0, st, ld);
            cycles++;
            if (st != BUSY) break;
        end
        check("chg_state", 32'(st), 32'(ACCESS));
        check("chg_cycles", cycles, lat[0] + 1);
        drive(0, 1'b0, 1'b0, 32'h24, 32'h0);
        tick(); sample(0, st, ld); check("chg_free", 32'(st), 32'(FREE));
        model_mem[0][9] = 32'h0000AAAA;
        op(0, 1'b1, 1'b0, 32'h20, 32'h0, "chg_rb_20");
        op(0, 1'b1, 1'b0, 32'h24, 32'h0, "chg_rb_24");

        // Reset on the WAIT->RESP edge discards the write.
        op(0, 1'b0, 1'b1, 32'h30, 32'h11110000, "rstmid_pre");
        drive(0, 1'b0, 1'b1, 32'h30, 32'h55);
        tick(); sample(0, st, ld); check("rstmid_busy1", 32'(st), 32'(BUSY));
        tick(); sample(0, st, ld); check("rstmid_busy2", 32'(st), 32'(BUSY));
        rst = 1'b1;
        tick(); sample(0, st, ld);
        check("rstmid_state", 32'(st), 32'(FREE));
        check("rstmid_load", ld, 32'h0);
        rst = 1'b0;
        model_load[0] = 32'h0;
        model_load[1] = 32'h0;
        drive(0, 1'b0, 1'b0, 32'h30, 32'h0);
        tick(); sample(0, st, ld); check("rstmid_free", 32'(st), 32'(FREE));
        op(0, 1'b1, 1'b0, 32'h30, 32'h0, "rstmid_rb_30");

        // Random mix of valid and faulting requests on both instances.
        for (int k = 0; k < 120; k++) begin
            int          d;
            int          kind;
            logic        ren;
            logic        wen;
            logic [31:0] addr;
            d    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            ren  = 1'($urandom_range(0, 1));
            wen  = !ren;
            addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            if (kind == 0) addr = addr | 32'($urandom_range(1, 3));
            else if (kind == 1) addr = 32'(4 * DEPTH + 4 * $urandom_range(0, 15));
            else if (kind == 2) begin ren = 1'b1; wen = 1'b1; end
            op(d, ren, wen, addr, $urandom, "rand");
        end

        check("exp_q_empty", exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
